// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter driving the single register-file write port
// from an ALU result path and a buffered LSU (load) result path.
// Latency: 1 cycle from ALU handshake / FIFO pop to rf_we. Backpressure:
// alu_ready drops only while the LSU FIFO is full, and lsu_ready = !full && !flush.
//
// Ports:
//   clk, rst (async, active-high)  flush (drops all buffered loads)
//   alu_valid/alu_ready/alu_rd/alu_data : single-cycle ALU results
//   lsu_valid/lsu_ready/lsu_rd/lsu_data : variable-latency load results
//   rf_we/rf_waddr/rf_wdata             : registered register-file write port
//   pend_count                          : number of buffered load results
// Optional macro WB_PERF_EN adds perf_stall_cnt / perf_wr_cnt (32-bit, wrapping).
module wb_arbiter #(
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5,
   parameter int DEPTH       = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [RFIDX_WIDTH-1:0]   alu_rd,
   input  logic [XLEN-1:0]          alu_data,
   input  logic                     lsu_valid,
   output logic                     lsu_ready,
   input  logic [RFIDX_WIDTH-1:0]   lsu_rd,
   input  logic [XLEN-1:0]          lsu_data,
   output logic                     rf_we,
   output logic [RFIDX_WIDTH-1:0]   rf_waddr,
   output logic [XLEN-1:0]          rf_wdata,
`ifdef WB_PERF_EN
   output logic [31:0]              perf_stall_cnt,
   output logic [31:0]              perf_wr_cnt,
`endif
   output logic [$clog2(DEPTH):0]   pend_count
);

   localparam int PTRW = $clog2(DEPTH);
   localparam int CW   = PTRW + 1;

   logic [RFIDX_WIDTH-1:0] r_mem_rd   [DEPTH];
   logic [XLEN-1:0]        r_mem_data [DEPTH];
   logic [PTRW-1:0]        r_wptr;
   logic [PTRW-1:0]        r_rptr;
   logic [CW-1:0]          r_count;

   logic                   r_rf_we;
   logic [RFIDX_WIDTH-1:0] r_rf_waddr;
   logic [XLEN-1:0]        r_rf_wdata;

   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_sel_vld;
   logic [RFIDX_WIDTH-1:0] w_sel_rd;
   logic [XLEN-1:0]        w_sel_data;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign lsu_ready = !w_full && !flush;
   assign alu_ready = !w_full && !rst;
   assign w_push    = lsu_valid && lsu_ready;

   // Full FIFO beats the ALU so loads cannot be starved by a busy ALU.
   // A flush kills the FIFO pop but leaves the ALU path alone.
   always_comb begin
      w_sel_vld  = 1'b0;
      w_pop      = 1'b0;
      w_sel_rd   = r_mem_rd[r_rptr];
      w_sel_data = r_mem_data[r_rptr];
      if (w_full) begin
         w_pop     = !flush;
         w_sel_vld = !flush;
      end else if (alu_valid) begin
         w_sel_vld  = 1'b1;
         w_sel_rd   = alu_rd;
         w_sel_data = alu_data;
      end else if (!w_empty) begin
         w_pop     = !flush;
         w_sel_vld = !flush;
      end
   end

   // Storage has no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_rd[r_wptr]   <= lsu_rd;
         r_mem_data[r_wptr] <= lsu_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Writes to x0 are consumed silently; address/data hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else begin
         r_rf_we <= w_sel_vld && (w_sel_rd != '0);
         if (w_sel_vld && (w_sel_rd != '0)) begin
            r_rf_waddr <= w_sel_rd;
            r_rf_wdata <= w_sel_data;
         end
      end
   end

   assign rf_we      = r_rf_we;
   assign rf_waddr   = r_rf_waddr;
   assign rf_wdata   = r_rf_wdata;
   assign pend_count = r_count;

`ifdef WB_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_stall <= '0;
         r_perf_wr    <= '0;
      end else begin
         r_perf_stall <= r_perf_stall + 32'(alu_valid && !alu_ready);
         r_perf_wr    <= r_perf_wr + 32'(r_rf_we);
      end
   end

   assign perf_stall_cnt = r_perf_stall;
   assign perf_wr_cnt    = r_perf_wr;
`endif

endmodule
